// File: rtl/ex3_serial_rx.sv
// ============================================================================
// Module   : ex3_serial_rx
// Brief    : Serial excess-3 digit receiver with range check and digit FIFO.
//            Optional 5-bit frame with odd parity when EX3_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ex3_serial_rx #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  input  logic sin_valid,
  input  logic flush,
  output logic w,
  output logic x,
  output logic y,
  output logic z,
  output logic out_valid,
  input  logic out_ready,
  output logic err,
  output logic ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
  localparam logic [3:0]    c_code_lo = 4'd3;
  localparam logic [3:0]    c_code_hi = 4'd12;
`ifdef EX3_PARITY_EN
  localparam logic [2:0]    c_last_bit = 3'd4;
`else
  localparam logic [2:0]    c_last_bit = 3'd3;
`endif

  logic [2:0]    r_bitcnt;
  logic [3:0]    r_shift;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_head;
  logic          r_err;
  logic          r_ovf;

  logic          w_sample;
  logic          w_last;
  logic [3:0]    w_code;
  logic          w_good;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic [AW:0]   w_count_n;
  logic [AW-1:0] w_rptr_n;
  logic [3:0]    w_head_n;

  assign w_sample = sin_valid & ~flush;
  assign w_last   = w_sample && (r_bitcnt == c_last_bit);

`ifdef EX3_PARITY_EN
  // Data nibble is complete before the parity bit; parity closes the frame.
  assign w_code = r_shift;
  assign w_good = (w_code >= c_code_lo) && (w_code <= c_code_hi) && (^{r_shift, sin});
`else
  assign w_code = {r_shift[2:0], sin};
  assign w_good = (w_code >= c_code_lo) && (w_code <= c_code_hi);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= 3'd0;
      r_shift  <= 4'd0;
    end else if (flush) begin
      r_bitcnt <= 3'd0;
      r_shift  <= 4'd0;
    end else if (sin_valid) begin
      r_bitcnt <= w_last ? 3'd0 : r_bitcnt + 3'd1;
`ifdef EX3_PARITY_EN
      if (!w_last) r_shift <= {r_shift[2:0], sin};
`else
      r_shift <= {r_shift[2:0], sin};
`endif
    end
  end

  assign out_valid  = (r_count != '0);
  assign w_full     = (r_count == c_depth);
  assign w_pop      = out_valid & out_ready;
  assign w_push_req = w_last & w_good;
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_pop)      w_count_n = r_count + c_cnt_one;
    else if (!w_push && w_pop) w_count_n = r_count - c_cnt_one;
  end

  assign w_rptr_n = w_pop ? r_rptr + c_ptr_one : r_rptr;

  // Bypass the incoming digit when it becomes the head on the same edge.
  always_comb begin
    w_head_n = r_mem[w_rptr_n];
    if (w_push && (r_wptr == w_rptr_n)) w_head_n = w_code;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= 4'd0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      r_rptr  <= w_rptr_n;
      r_count <= w_count_n;
      if (w_count_n != '0) r_head <= w_head_n;
      r_err   <= w_last & ~w_good;
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign w   = r_head[3];
  assign x   = r_head[2];
  assign y   = r_head[1];
  assign z   = r_head[0];
  assign err = r_err;
  assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ex3_serial_rx.sv
// ============================================================================
// Module   : tb_ex3_serial_rx
// Brief    : Self-checking bench for ex3_serial_rx; scoreboard queue of digits.
//            Parity cases are compiled in when EX3_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ex3_serial_rx;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic w, x, y, z, out_valid, err, ovf;

  ex3_serial_rx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .w(w), .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver-to-scoreboard handshake: set while the last bit of a frame is offered.
  logic       m_done = 1'b0;
  logic       m_good = 1'b0;
  logic [3:0] m_code = 4'd0;

  logic [3:0] q[$];
  logic       exp_err  = 1'b0;
  logic       exp_ovf  = 1'b0;
  logic [3:0] exp_last = 4'd0;

  // Inputs change just after posedge, so negedge sees both stable outputs and
  // the inputs that the next posedge will act upon.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_err  = 1'b0;
      exp_ovf  = 1'b0;
      exp_last = 4'd0;
    end else begin
      logic full, pop;
      chk("out_valid", out_valid, q.size() != 0);
      chk("head", {w, x, y, z}, (q.size() != 0) ? q[0] : exp_last);
      chk("err", err, exp_err);
      chk("ovf", ovf, exp_ovf);
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      exp_err = m_done && !m_good;
      if (m_done && m_good) begin
        if (!full || pop) q.push_back(m_code);
        else exp_ovf = 1'b1;
      end
      if (q.size() != 0) exp_last = q[0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic rdy, input logic last,
                          input logic good, input logic [3:0] code);
    sin = b; sin_valid = 1'b1; out_ready = rdy;
    m_done = last; m_good = good; m_code = code;
    tick();
    sin_valid = 1'b0; m_done = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] code, input logic good, input logic rdy,
                            input logic rdy_last, input int gap, input logic badpar);
    logic par;
    par = ~(^code) ^ badpar;
    for (int i = 3; i >= 0; i--) begin
`ifdef EX3_PARITY_EN
      send_bit(code[i], rdy, 1'b0, good, code);
`else
      send_bit(code[i], (i == 0) ? rdy_last : rdy, i == 0, good, code);
`endif
      for (int g = 0; g < gap; g++) begin
        sin = $urandom_range(0, 1);
        tick();
      end
    end
`ifdef EX3_PARITY_EN
    send_bit(par, rdy_last, 1'b1, good, code);
`else
    if (badpar) sin = par;
`endif
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", out_valid, 1'b0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_head", {w, x, y, z}, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] code;
    logic       rdy;
    int         gap;
    logic       good;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'b0011, 1'b1, 0, 1'b1};
    tbl[1] = '{4'b1100, 1'b1, 1, 1'b1};
    tbl[2] = '{4'b0010, 1'b1, 0, 1'b0};
    tbl[3] = '{4'b1101, 1'b1, 2, 1'b0};
    tbl[4] = '{4'b0000, 1'b1, 0, 1'b0};
    tbl[5] = '{4'b1001, 1'b0, 0, 1'b1};
    tbl[6] = '{4'b0110, 1'b1, 0, 1'b1};
    tbl[7] = '{4'b1011, 1'b1, 1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_head", {w, x, y, z}, 4'b0000);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Single good digit, delivered for one cycle.
    send_frame(4'b0101, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    chk("r28_head", {w, x, y, z}, 4'b0101);
    chk("r28_valid", out_valid, 1'b1);
    chk("r28_err", err, 1'b0);
    tick();
    chk("r28_valid_drop", out_valid, 1'b0);

    // Out-of-range frame.
    send_frame(4'b1111, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    chk("r29_err", err, 1'b1);
    chk("r29_valid", out_valid, 1'b0);
    tick();
    chk("r29_err_end", err, 1'b0);

    for (int i = 0; i < 8; i++)
      send_frame(tbl[i].code, tbl[i].good, tbl[i].rdy, tbl[i].rdy, tbl[i].gap, 1'b0);
    drain();

    // Overflow with DEPTH=2 and no consumer.
    send_frame(4'b0011, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'b0100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'b1100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("r30_head", {w, x, y, z}, 4'b0011);
    chk("r30_ovf", ovf, 1'b1);
    chk("r30_err", err, 1'b0);
    drain();
    chk("r30_ovf_sticky", ovf, 1'b1);
    pulse_rst();

    // Full FIFO, last bit coincides with a pop.
    send_frame(4'b0011, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'b0100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'b1000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk("r31_ovf", ovf, 1'b0);
    chk("r31_head", {w, x, y, z}, 4'b0100);
    drain();
    chk("r31_last", {w, x, y, z}, 4'b1000);

    // Partial frame discarded by flush.
    send_bit(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    flush = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    tick();
    flush = 1'b0; sin_valid = 1'b0;
    send_frame(4'b0111, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("r32_flush_head", {w, x, y, z}, 4'b0111);
    chk("r32_flush_err", err, 1'b0);
    drain();

    // Partial frame discarded by reset.
    send_bit(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    pulse_rst();
    send_frame(4'b0111, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("r32_rst_head", {w, x, y, z}, 4'b0111);
    chk("r32_rst_err", err, 1'b0);
    drain();

`ifdef EX3_PARITY_EN
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("r33_good", {w, x, y, z}, 4'b0110);
    drain();
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("r33_bad_err", err, 1'b1);
    chk("r33_bad_valid", out_valid, 1'b0);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ex3_serial_rx.md
EX3_SERIAL_RX -- requirements
Module: ex3_serial_rx

Interface
REQ-001 Parameter: DEPTH, default 2, digit FIFO depth in entries (power of 2, minimum 2).
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: sin  input  1  serial excess-3 data bit, MSB (w) first.
REQ-005 Port: sin_valid  input  1  sin is sampled on a clk edge only when high.
REQ-006 Port: flush  input  1  synchronous discard of any partially received frame.
REQ-007 Port: w, x, y, z  output  1 each  excess-3 digit at FIFO head, w = MSB; these feed the excess-3 to BCD converter directly.
REQ-008 Port: out_valid  output  1  FIFO head holds a digit.
REQ-009 Port: out_ready  input  1  consumer accepts head when out_valid and out_ready are both high.
REQ-010 Port: err  output  1  one-cycle pulse on rejected frame.
REQ-011 Port: ovf  output  1  sticky, set when a good digit is dropped because the FIFO is full.

Function
REQ-012 The block SHALL shift sin into a 4-bit shift register on each cycle with sin_valid high, and increment a frame bit counter.
REQ-013 Frame length SHALL be 4 bits (5 with EX3_PARITY_EN); the counter wraps to 0 on the cycle the last frame bit is sampled.
REQ-014 A completed frame is good iff its code lies in 0011..1100 inclusive (and parity passes when enabled); otherwise it is rejected.
REQ-015 Good frame: pushed into the FIFO on the last-bit edge; out_valid rises the following cycle if the FIFO was empty (latency 1 cycle from last-bit edge).
REQ-016 Rejected frame: not pushed; err high for exactly the cycle after the last-bit edge.
REQ-017 Pop occurs on any edge with out_valid and out_ready high; w,x,y,z show the next entry the cycle after.
REQ-018 out_ready while out_valid low SHALL have no effect; w,x,y,z hold their last value (0000 after reset) while empty.
REQ-019 Push to full FIFO with simultaneous pop SHALL succeed (no drop, no ovf).
REQ-020 Push to full FIFO without pop: digit dropped, ovf set and held until rst; err not asserted.
REQ-021 Simultaneous push and pop on a non-full FIFO: occupancy unchanged, order preserved.
REQ-022 flush high: bit counter and shift register cleared that edge, sin ignored that cycle; FIFO contents, ovf untouched.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.

Reset
REQ-024 rst high SHALL immediately clear: bit counter, shift register, FIFO pointers/occupancy, w,x,y,z=0000, out_valid=0, err=0, ovf=0.
REQ-025 rst asserted mid-frame SHALL discard the partial frame; after deassertion the next sampled bit is bit 0 of a new frame.

Configuration
REQ-026 Macro EX3_PARITY_EN defined: frame is 5 bits, 5th bit is odd parity over the 4 data bits; parity failure rejects the frame per REQ-016.
REQ-027 Macro EX3_PARITY_EN undefined: frame is 4 bits, no parity logic present.

Verification
REQ-028 Serial 0,1,0,1 (0101), out_ready=1 -> cycle after 4th bit: wxyz=0101, out_valid=1 for one cycle, err=0.
REQ-029 Serial 1,1,1,1 (1111) -> err pulses 1 cycle, out_valid stays 0, FIFO empty.
REQ-030 DEPTH=2, out_ready=0, send 0011, 0100, 1100 -> head 0011, out_valid=1, ovf=1; then out_ready=1 drains 0011, 0100 in order, out_valid=0.
REQ-031 FIFO full, last bit of 1000 arrives on same edge as pop -> no ovf, drain order preserved with 1000 last.
REQ-032 Two bits of a frame, then flush, then 0,1,1,1 -> wxyz=0111 delivered; same with rst instead of flush -> identical result.
REQ-033 EX3_PARITY_EN: 0,1,1,0 + parity 1 -> accepted 0110; 0,1,1,0 + parity 0 -> err pulse, no push.
